// File: rtl/ntt_addr_gen.sv
`default_nettype none
// ntt_addr_gen: conflict-free two-bank read/write address schedule for an in-place forward NTT.
// Coefficient x lives in bank ^x at address x>>1; writes trail their reads by BF_LAT+1 cycles.
module ntt_addr_gen #(
  parameter int LOG_N  = 8,
  parameter int BF_LAT = 4,
  localparam int AW    = LOG_N - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          bank_en,
  output logic          ren,
  output logic [AW-1:0] b0_ra,
  output logic [AW-1:0] b1_ra,
  output logic          bf_valid,
  output logic          rd_swap,
  output logic [LOG_N-1:0] tw_idx,
  output logic          wen,
  output logic [AW-1:0] b0_wa,
  output logic [AW-1:0] b1_wa,
  output logic          wr_swap
);

  localparam int SW = $clog2(LOG_N + 1);
  localparam int DW = $clog2(BF_LAT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] c, c_n;
  logic [SW-1:0] s, s_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          last, last_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c     <= '0;
      s     <= SW'(LOG_N - 1);
      dcnt  <= '0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      c     <= c_n;
      s     <= s_n;
      dcnt  <= dcnt_n;
      last  <= last_n;
    end
  end

  // c and s hold the issue presented on the outputs; the stage steps down as c wraps.
  always_comb begin
    state_n = state;
    c_n     = c;
    s_n     = s;
    dcnt_n  = dcnt;
    last_n  = last;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          c_n     = '0;
          s_n     = SW'(LOG_N - 1);
        end
      end
      RUN: begin
        if (c == '1) begin
          state_n = DRAIN;
          c_n     = '0;
          s_n     = (s == '0) ? SW'(LOG_N - 1) : s - SW'(1);
          last_n  = (s == '0);
          dcnt_n  = '0;
        end else begin
          c_n = c + AW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == DW'(BF_LAT)) begin
          state_n = last ? DONE : RUN;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        last_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  logic             issue_n;
  logic [LOG_N-1:0] cz, mask, j, p, tw;
  logic             jb;
  logic [AW-1:0]    ra0, ra1;

  // Addresses are formed from the next-cycle counters so every output leaves a flop.
  always_comb begin
    issue_n = (state_n == RUN);
    cz      = {1'b0, c_n};
    mask    = (LOG_N'(1) << s_n) - LOG_N'(1);
    j       = ((cz & ~mask) << 1) | (cz & mask);
    p       = j | (LOG_N'(1) << s_n);
    jb      = ^j;
    tw      = (LOG_N'(1) << (SW'(LOG_N - 1) - s_n)) + (cz >> s_n);
    ra0     = jb ? p[LOG_N-1:1] : j[LOG_N-1:1];
    ra1     = jb ? j[LOG_N-1:1] : p[LOG_N-1:1];
  end

  logic             sw_t;
  logic [LOG_N-1:0] tw_t, tw_d;
  logic [BF_LAT:0]  v_d, sw_d;
  logic [AW-1:0]    a0_d [BF_LAT+1];
  logic [AW-1:0]    a1_d [BF_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren   <= 1'b0;
      b0_ra <= '0;
      b1_ra <= '0;
      sw_t  <= 1'b0;
      tw_t  <= '0;
      tw_d  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      v_d   <= '0;
      sw_d  <= '0;
      for (int k = 0; k <= BF_LAT; k++) begin
        a0_d[k] <= '0;
        a1_d[k] <= '0;
      end
    end else begin
      ren   <= issue_n;
      b0_ra <= issue_n ? ra0 : '0;
      b1_ra <= issue_n ? ra1 : '0;
      sw_t  <= issue_n & jb;
      tw_t  <= issue_n ? tw : '0;
      tw_d  <= tw_t;
      busy  <= (state_n == RUN) || (state_n == DRAIN);
      done  <= (state_n == DONE);
      v_d   <= {v_d[BF_LAT-1:0], ren};
      sw_d  <= {sw_d[BF_LAT-1:0], sw_t};
      a0_d[0] <= b0_ra;
      a1_d[0] <= b1_ra;
      for (int k = 1; k <= BF_LAT; k++) begin
        a0_d[k] <= a0_d[k-1];
        a1_d[k] <= a1_d[k-1];
      end
    end
  end

  assign bank_en  = busy;
  assign bf_valid = v_d[0];
  assign rd_swap  = sw_d[0];
  assign tw_idx   = tw_d;
  assign wen      = v_d[BF_LAT];
  assign b0_wa    = a0_d[BF_LAT];
  assign b1_wa    = a1_d[BF_LAT];
  assign wr_swap  = sw_d[BF_LAT];

endmodule
`default_nettype wire

// File: tb/tb_ntt_addr_gen.sv
`default_nettype none
// tb_ntt_addr_gen: directed bench with a two-bank memory model and an identity butterfly.
module tb_ntt_addr_gen;
  localparam int LOG_N  = 8;
  localparam int BF_LAT = 4;
  localparam int AW     = LOG_N - 1;
  localparam int HALF   = 1 << AW;
  localparam int STG    = HALF + BF_LAT + 1;
  localparam int TOTAL  = LOG_N * STG;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, bank_en, ren, bf_valid, rd_swap, wen, wr_swap;
  logic [AW-1:0] b0_ra, b1_ra, b0_wa, b1_wa;
  logic [LOG_N-1:0] tw_idx;

  ntt_addr_gen #(.LOG_N(LOG_N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bank_en(bank_en),
    .ren(ren), .b0_ra(b0_ra), .b1_ra(b1_ra), .bf_valid(bf_valid), .rd_swap(rd_swap),
    .tw_idx(tw_idx), .wen(wen), .b0_wa(b0_wa), .b1_wa(b1_wa), .wr_swap(wr_swap)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int par(input int x);
    return $countones(x) & 1;
  endfunction

  function automatic int ins0(input int cv, input int sv);
    return ((cv >> sv) << (sv + 1)) | (cv & ((1 << sv) - 1));
  endfunction

  int mem0 [HALF];
  int mem1 [HALF];
  int iq_t[$], iq_a0[$], iq_a1[$], iq_sw[$], dq_a[$], dq_b[$];

  bit mon_on = 1'b0;
  int s_cyc, n_issue, done_cnt, done_off, gap;
  bit seen, prev_iss, iss;
  int m_off, m_k, m_pos, m_sv, m_cv, m_j, m_p, m_e0, m_e1, m_a, m_b, m_t;
  int prev_j, prev_p, prev_tw, prev_q0, prev_q1, prev_sw;

  task automatic begin_run();
    iq_t.delete(); iq_a0.delete(); iq_a1.delete(); iq_sw.delete();
    dq_a.delete(); dq_b.delete();
    n_issue = 0; done_cnt = 0; done_off = -1; gap = 0; seen = 0; prev_iss = 0;
  endtask

  // Per-cycle schedule model: what every cycle after start should look like.
  always @(negedge clk) begin
    if (mon_on) begin
      m_off = cyc - s_cyc;
      iss   = 1'b0;
      if (m_off >= 1 && m_off <= TOTAL) begin
        m_k   = (m_off - 1) / STG;
        m_pos = (m_off - 1) % STG;
        iss   = (m_pos < HALF);
        m_sv  = LOG_N - 1 - m_k;
        m_cv  = m_pos;
      end
      check("busy", busy, (m_off >= 1 && m_off <= TOTAL));
      check("bank_en", bank_en, (m_off >= 1 && m_off <= TOTAL));
      check("done", done, (m_off == TOTAL + 1));
      check("ren", ren, iss);
      check("bf_valid", bf_valid, prev_iss);
      if (prev_iss) begin
        check("rd_swap", rd_swap, prev_sw);
        check("tw_idx", tw_idx, prev_tw);
        m_a = rd_swap ? prev_q1 : prev_q0;
        m_b = rd_swap ? prev_q0 : prev_q1;
        check("rd_data_j", m_a, prev_j);
        check("rd_data_partner", m_b, prev_p);
        dq_a.push_back(m_a);
        dq_b.push_back(m_b);
        iq_sw.push_back(rd_swap);
      end
      if (wen) begin
        if (iq_t.size() == 0 || dq_a.size() == 0 || iq_sw.size() == 0) begin
          check("wen_unexpected", 1, 0);
        end else begin
          m_t = iq_t.pop_front();
          check("wr_latency", cyc - m_t, BF_LAT + 1);
          check("b0_wa", b0_wa, iq_a0.pop_front());
          check("b1_wa", b1_wa, iq_a1.pop_front());
          check("wr_swap", wr_swap, iq_sw.pop_front());
          m_a = dq_a.pop_front();
          m_b = dq_b.pop_front();
          mem0[b0_wa] = wr_swap ? m_b : m_a;
          mem1[b1_wa] = wr_swap ? m_a : m_b;
        end
      end
      if (iss) begin
        m_j  = ins0(m_cv, m_sv);
        m_p  = m_j + (1 << m_sv);
        m_e0 = par(m_j) ? (m_p >> 1) : (m_j >> 1);
        m_e1 = par(m_j) ? (m_j >> 1) : (m_p >> 1);
        check("b0_ra", b0_ra, m_e0);
        check("b1_ra", b1_ra, m_e1);
        iq_t.push_back(cyc);
        iq_a0.push_back(b0_ra);
        iq_a1.push_back(b1_ra);
        prev_q0 = mem0[b0_ra];
        prev_q1 = mem1[b1_ra];
        prev_j  = m_j;
        prev_p  = m_p;
        prev_sw = par(m_j);
        prev_tw = (1 << (LOG_N - 1 - m_sv)) + (m_cv >> m_sv);
        n_issue++;
      end
      if (ren !== 1'b1 && seen) gap++;
      if (ren === 1'b1) begin
        if (gap > 0) check("stage_gap", gap, BF_LAT + 1);
        gap  = 0;
        seen = 1'b1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_off = m_off;
      end
      prev_iss = iss;
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_bank_en"}, bank_en, 0);
    check({pfx, "_ren"}, ren, 0);
    check({pfx, "_b0_ra"}, b0_ra, 0);
    check({pfx, "_b1_ra"}, b1_ra, 0);
    check({pfx, "_bf_valid"}, bf_valid, 0);
    check({pfx, "_rd_swap"}, rd_swap, 0);
    check({pfx, "_tw_idx"}, tw_idx, 0);
    check({pfx, "_wen"}, wen, 0);
    check({pfx, "_b0_wa"}, b0_wa, 0);
    check({pfx, "_b1_wa"}, b1_wa, 0);
    check({pfx, "_wr_swap"}, wr_swap, 0);
  endtask

  task automatic first_issue(input string pfx);
    check({pfx, "_ren"}, ren, 1);
    check({pfx, "_b0_ra"}, b0_ra, 0);
    check({pfx, "_b1_ra"}, b1_ra, 64);
    @(negedge clk);
    check({pfx, "_bf_valid"}, bf_valid, 1);
    check({pfx, "_rd_swap"}, rd_swap, 0);
    check({pfx, "_tw_idx"}, tw_idx, 1);
  endtask

  task automatic end_run(input string pfx);
    int bad;
    check({pfx, "_issues"}, n_issue, 1024);
    check({pfx, "_done_count"}, done_cnt, 1);
    check({pfx, "_done_offset"}, done_off, 1065);
    check({pfx, "_writes_pending"}, iq_t.size(), 0);
    check({pfx, "_busy_after"}, busy, 0);
    bad = 0;
    for (int x = 0; x < 2 * HALF; x++) begin
      if (par(x) == 1 && mem1[x >> 1] != x) bad++;
      if (par(x) == 0 && mem0[x >> 1] != x) bad++;
    end
    check({pfx, "_mem_intact"}, bad, 0);
  endtask

  initial begin
    for (int x = 0; x < 2 * HALF; x++) begin
      if (par(x) == 1) mem1[x >> 1] = x;
      else             mem0[x >> 1] = x;
    end
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // Run 1: plain schedule with directed spot checks.
    begin_run();
    s_cyc  = cyc;
    mon_on = 1'b1;
    pulse_start();
    first_issue("run1_first");
    wait_until(s_cyc + 933);
    check("run1_s0c1_ren", ren, 1);
    check("run1_s0c1_b0_ra", b0_ra, 1);
    check("run1_s0c1_b1_ra", b1_ra, 1);
    @(negedge clk);
    check("run1_s0c1_rd_swap", rd_swap, 1);
    check("run1_s0c1_tw_idx", tw_idx, 129);
    wait_until(s_cyc + 1072);
    end_run("run1");
    mon_on = 1'b0;

    // Run 2: extra start pulses while running must change nothing.
    begin_run();
    s_cyc  = cyc;
    mon_on = 1'b1;
    pulse_start();
    wait_until(s_cyc + 10);
    pulse_start();
    wait_until(s_cyc + 131);
    pulse_start();
    wait_until(s_cyc + 600);
    pulse_start();
    wait_until(s_cyc + 1072);
    end_run("run2");
    mon_on = 1'b0;

    // Run 3: abort by reset during the drain of stage s=3.
    s_cyc = cyc;
    pulse_start();
    wait_until(s_cyc + 663);
    check("abort_pre_ren", ren, 0);
    check("abort_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_abort_wen", wen, 0);
      check("post_abort_ren", ren, 0);
      check("post_abort_busy", busy, 0);
    end

    // Run 4: fresh start after abort.
    begin_run();
    s_cyc  = cyc;
    mon_on = 1'b1;
    pulse_start();
    first_issue("run4_first");
    wait_until(s_cyc + 1072);
    end_run("run4");
    mon_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ntt_addr_gen.md
NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 SHALL have parameter LOG_N, default 8, meaning log2 of the number of coefficients N.
REQ-002 SHALL have parameter BF_LAT, default 4, meaning the butterfly pipeline depth in cycles from the cycle read data is valid to the cycle the result is valid.
REQ-003 SHALL derive localparam AW = LOG_N-1 as the width of each bank address.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle request to run a full forward NTT schedule.
REQ-007 SHALL have outputs busy (1 bit), high while the schedule runs, and done (1 bit), a one-cycle completion pulse.
REQ-008 SHALL have output bank_en, 1 bit, driving the EN input of both banks.
REQ-009 SHALL have outputs ren (1 bit), b0_ra (AW bits) and b1_ra (AW bits): the read strobe and read addresses for bank 0 and bank 1.
REQ-010 SHALL have outputs bf_valid (1 bit), rd_swap (1 bit) and tw_idx (LOG_N bits), all aligned with bank Q data.
REQ-011 SHALL have outputs wen (1 bit), b0_wa (AW bits), b1_wa (AW bits) and wr_swap (1 bit): the write strobe, write addresses and write-data routing.

Function
REQ-012 Mapping: coefficient index x SHALL reside in bank XOR-reduce(x) at bank address x[LOG_N-1:1].
REQ-013 Conflict freedom: the two operands of a butterfly differ in exactly one index bit, so they SHALL always map to different banks.
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN and DONE, with these transitions:
 - IDLE to RUN on start.
 - RUN to DRAIN after the last issue of a stage.
 - DRAIN to RUN (next stage) after BF_LAT+1 cycles.
 - DRAIN to DONE after the drain of the final stage.
 - DONE to IDLE after one cycle.
REQ-015 Stage s SHALL run from LOG_N-1 down to 0, with len = 2^s.
REQ-016 The butterfly counter c SHALL run from 0 to N/2-1 within each stage, with one issue per RUN cycle.
REQ-017 For each issue, index j SHALL be c with a 0 bit inserted at bit position s, and its partner SHALL be j+len.
REQ-018 For each issue, tw_idx SHALL equal N/(2*len) + (c >> s).
REQ-019 In an issue cycle T, outputs SHALL be registered so that:
 - ren=1;
 - b0_ra and b1_ra are the bank addresses of whichever of j or partner maps to that bank.
REQ-020 In cycle T+1, bf_valid SHALL be 1, rd_swap SHALL be XOR-reduce(j) (1 when j is in bank 1), and tw_idx SHALL hold the value for the issue.
REQ-021 In cycle T+1+BF_LAT, wen SHALL be 1, and b0_wa, b1_wa and wr_swap SHALL equal the T values of b0_ra, b1_ra and rd_swap, delivered through a shift register.
REQ-022 DRAIN SHALL hold ren=0 for BF_LAT+1 cycles, so that every write of a stage commits before the first read of the next stage.
REQ-023 bank_en SHALL equal busy, and busy SHALL be 1 in RUN and DRAIN.
REQ-024 The cycle count from start to done SHALL be LOG_N*(N/2+BF_LAT+1)+1: start is sampled in cycle S, the first issue is in S+1, and done is in S+1065 for the defaults.
REQ-025 In DONE, done SHALL be 1 and busy SHALL be 0.
REQ-026 When not driven active, ren, wen, bf_valid and done SHALL be 0, and addresses, rd_swap, wr_swap and tw_idx SHALL be 0.
REQ-027 start SHALL be ignored when it arrives in RUN, DRAIN or DONE.
REQ-028 The counter SHALL wrap to 0 at N/2-1 coincident with the stage change.

Reset
REQ-029 While rst_n=0, the block SHALL be asynchronously in state IDLE with every output 0, the counter 0, s=LOG_N-1, and the write delay line cleared.
REQ-030 Reset asserted mid-schedule SHALL abort the schedule: no pending write is emitted after release, and a new start is required.

Verification
REQ-031 The bench SHALL check the first issue after start: ren=1, b0_ra=0, b1_ra=64; next cycle rd_swap=0, tw_idx=1, bf_valid=1.
REQ-032 The bench SHALL check stage s=0, c=1: j=2 and partner 3, giving b1_ra=1, b0_ra=1; next cycle rd_swap=1, tw_idx=129.
REQ-033 The bench SHALL check write alignment: for each issue at T, wen=1 at T+5 with b0_wa, b1_wa and wr_swap equal to the issue values; a model of two banks plus an identity butterfly SHALL leave memory contents unchanged.
REQ-034 The bench SHALL check stage boundaries: exactly 5 ren=0 cycles between stages, no same-bank read conflict across all 1024 issues, and done exactly at S+1065 with busy low afterwards.
REQ-035 The bench SHALL check start pulses asserted in RUN: the schedule timing is unchanged and only one done occurs.
REQ-036 The bench SHALL check rst_n driven low in stage 3, DRAIN: all outputs are 0 immediately, no wen appears after release, and a subsequent start reproduces the REQ-031 values.
